// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N-way channel multiplexer.
package mux_pkg;

  localparam logic MODE_EXPLICIT = 1'b0;
  localparam logic MODE_RR       = 1'b1;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mux_n_reg_rr_arbiter.sv
// Rotate-priority arbiter: first requester at or after ptr, wrapping modulo CHANNELS.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    grant,
  output logic                grant_found
);

  // One extra bit so ptr+i never overflows before the modulo fold.
  always_comb begin : search
    logic [SEL_W:0] sum;
    sum         = '0;
    grant       = '0;
    grant_found = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum = {1'b0, ptr} + (SEL_W+1)'(i);
      if (sum >= (SEL_W+1)'(CHANNELS)) begin
        sum = sum - (SEL_W+1)'(CHANNELS);
      end else begin
        sum = sum;
      end
      if (!grant_found && req[sum[SEL_W-1:0]]) begin
        grant_found = 1'b1;
        grant       = sum[SEL_W-1:0];
      end else begin
        grant_found = grant_found;
      end
    end
  end

endmodule

// File: rtl/mux_n_reg.sv
// Registered N-way data mux with per-channel valid/ready, explicit or round-robin selection.
module mux_n_reg
  import mux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          select,
  input  logic                      rr_mode,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_chan_q,  out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  logic [SEL_W-1:0] rr_grant;
  logic             rr_found;
  logic             sel_hit;
  logic [SEL_W-1:0] grant;
  logic             grant_found;
  logic [WIDTH-1:0] grant_data;
  logic             load_en;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .req         (in_valid),
    .ptr         (ptr_q),
    .grant       (rr_grant),
    .grant_found (rr_found)
  );

  assign load_en = !out_valid_q || out_ready;

  // An out-of-range select never matches any channel, so it yields no grant.
  always_comb begin
    sel_hit = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (select == SEL_W'(k)) begin
        sel_hit = in_valid[k];
      end else begin
        sel_hit = sel_hit;
      end
    end
    if (rr_mode == MODE_RR) begin
      grant       = rr_grant;
      grant_found = rr_found;
    end else begin
      grant       = select;
      grant_found = sel_hit;
    end
  end

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant == SEL_W'(k)) begin
        grant_data  = in_data[k*WIDTH +: WIDTH];
        in_ready[k] = rst_n && load_en && grant_found;
      end else begin
        in_ready[k] = 1'b0;
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load_en && grant_found) begin
      out_data_d  = grant_data;
      out_chan_d  = grant;
      out_valid_d = 1'b1;
      if (rr_mode == MODE_RR) begin
        ptr_d = (grant == SEL_W'(CHANNELS-1)) ? '0 : grant + SEL_W'(1);
      end else begin
        ptr_d = ptr_q;
      end
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed bench for mux_n_reg: a 4-channel instance for the main function and a 3-channel one for range edges.
module tb_mux_n_reg;

  logic        clk;
  logic        rst_n;

  logic [31:0] in_data4;
  logic [3:0]  in_valid4, in_ready4;
  logic [1:0]  select4;
  logic        rr_mode4, out_valid4, out_ready4;
  logic [7:0]  out_data4;
  logic [1:0]  out_chan4;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [1:0]  select3;
  logic        rr_mode3, out_valid3, out_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;

  int n_tests;
  int n_fail;

  mux_n_reg #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .select(select4), .rr_mode(rr_mode4),
    .out_data(out_data4), .out_chan(out_chan4), .out_valid(out_valid4),
    .out_ready(out_ready4)
  );

  mux_n_reg #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .select(select3), .rr_mode(rr_mode3),
    .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out4(input string tag, input logic [7:0] d, input logic [1:0] c, input logic v);
    check({tag, "_data"},  32'(out_data4),  32'(d));
    check({tag, "_chan"},  32'(out_chan4),  32'(c));
    check({tag, "_valid"}, 32'(out_valid4), 32'(v));
  endtask

  task automatic check_out3(input string tag, input logic [7:0] d, input logic [1:0] c, input logic v);
    check({tag, "_data"},  32'(out_data3),  32'(d));
    check({tag, "_chan"},  32'(out_chan3),  32'(c));
    check({tag, "_valid"}, 32'(out_valid3), 32'(v));
  endtask

  initial begin
    logic [1:0] rr_seq [10];
    n_tests = 0;
    n_fail  = 0;
    rr_seq  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd1, 2'd3, 2'd1};

    rst_n      = 1'b0;
    in_data4   = 32'h43_32_21_10;
    in_valid4  = 4'b1111;
    select4    = 2'd0;
    rr_mode4   = 1'b0;
    out_ready4 = 1'b1;
    in_data3   = 24'hC2_B1_A0;
    in_valid3  = 3'b111;
    select3    = 2'd0;
    rr_mode3   = 1'b0;
    out_ready3 = 1'b1;
    #1;
    check("rst_in_ready4", 32'(in_ready4), 32'h0);
    check("rst_in_ready3", 32'(in_ready3), 32'h0);
    step();
    check_out4("rst", 8'h00, 2'd0, 1'b0);
    check("rst_in_ready4_edge", 32'(in_ready4), 32'h0);

    in_valid4 = 4'b0000;
    in_valid3 = 3'b000;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out4("idle", 8'h00, 2'd0, 1'b0);
      check("idle_in_ready", 32'(in_ready4), 32'h0);
    end

    // explicit select=2
    select4   = 2'd2;
    in_valid4 = 4'b1111;
    #1;
    check("expl_in_ready_pre", 32'(in_ready4), 32'h4);
    for (int i = 0; i < 2; i++) begin
      step();
      check_out4("expl", 8'h32, 2'd2, 1'b1);
      check("expl_in_ready", 32'(in_ready4), 32'h4);
    end
    // explicit select of an idle channel gives no grant and drains
    select4   = 2'd3;
    in_valid4 = 4'b0111;
    #1;
    check("expl_novalid_ready", 32'(in_ready4), 32'h0);
    step();
    check_out4("expl_drain", 8'h32, 2'd2, 1'b0);

    // round-robin from ptr 0 (explicit traffic left it untouched)
    rr_mode4  = 1'b1;
    in_valid4 = 4'b1111;
    #1;
    check("rr_first_ready", 32'(in_ready4), 32'h1);
    for (int i = 0; i < 10; i++) begin
      if (i == 6) in_valid4 = 4'b1010;
      step();
      check("rr_seq_chan", 32'(out_chan4), 32'(rr_seq[i]));
      check("rr_seq_valid", 32'(out_valid4), 32'h1);
    end
    check("rr_last_data", 32'(out_data4), 32'h21);

    // backpressure while holding 0x21 from channel 1, ptr now 2
    in_valid4  = 4'b1111;
    out_ready4 = 1'b0;
    #1;
    check("stall_ready", 32'(in_ready4), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out4("stall", 8'h21, 2'd1, 1'b1);
      check("stall_ready_hold", 32'(in_ready4), 32'h0);
    end
    out_ready4 = 1'b1;
    #1;
    check("release_ready", 32'(in_ready4), 32'h4);
    step();
    check_out4("release", 8'h32, 2'd2, 1'b1);

    // drain with no valid input, ptr stays 3
    in_valid4 = 4'b0000;
    step();
    check_out4("drain", 8'h32, 2'd2, 1'b0);

    // two loads (ch3, ch0) leave ptr at 1, then reset mid-cycle
    in_valid4 = 4'b1111;
    step();
    check_out4("pre_rst_a", 8'h43, 2'd3, 1'b1);
    step();
    check_out4("pre_rst_b", 8'h10, 2'd0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out4("async_rst", 8'h00, 2'd0, 1'b0);
    check("async_rst_ready", 32'(in_ready4), 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(in_ready4), 32'h1);
    step();
    check_out4("post_rst", 8'h10, 2'd0, 1'b1);

    // three-channel instance: out-of-range select
    in_valid4 = 4'b0000;
    select3   = 2'd1;
    in_valid3 = 3'b111;
    #1;
    check("c3_sel1_ready", 32'(in_ready3), 32'h2);
    step();
    check_out3("c3_sel1", 8'hB1, 2'd1, 1'b1);
    select3 = 2'd3;
    #1;
    check("c3_sel3_ready", 32'(in_ready3), 32'h0);
    step();
    check_out3("c3_sel3", 8'hB1, 2'd1, 1'b0);
    step();
    check("c3_sel3_idle_valid", 32'(out_valid3), 32'h0);

    // three-channel round-robin wrap: ptr 2, only ch0 valid
    rr_mode3  = 1'b1;
    in_valid3 = 3'b010;
    #1;
    check("c3_rr_a_ready", 32'(in_ready3), 32'h2);
    step();
    check_out3("c3_rr_a", 8'hB1, 2'd1, 1'b1);
    in_valid3 = 3'b001;
    #1;
    check("c3_wrap_ready", 32'(in_ready3), 32'h1);
    step();
    check_out3("c3_wrap", 8'hA0, 2'd0, 1'b1);
    in_valid3 = 3'b111;
    #1;
    check("c3_ptr1_ready", 32'(in_ready3), 32'h2);
    step();
    check_out3("c3_ptr1", 8'hB1, 2'd1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
